// File: rtl/lpc_pkg.sv
// Shared defaults and compute-FSM state encoding for the LPC frame sequencer.
package lpc_pkg;

  localparam int FRAME_LEN_DEFAULT = 160;
  localparam int ADDR_W_DEFAULT    = 8;

  typedef enum logic [2:0] {
    IDLE,
    AC_KICK,
    AC_GUARD,
    AC_RUN,
    LD_KICK,
    LD_RUN,
    OUT
  } seq_state_e;

endpackage

// File: rtl/lpc_pingpong_capture.sv
// Capture side of the two-bank ping-pong sample buffer: write address, bank
// select, per-bank full flags and the sticky overrun flag.
module lpc_pingpong_capture
  import lpc_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEFAULT,
  parameter int ADDR_W    = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic              release_en,
  input  logic              release_bank,
  output logic              sample_ready,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        bank_full,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  logic              wr_bank_q,   wr_bank_d;
  logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic              overrun_q,   overrun_d;

  assign sample_ready = ~bank_full_q[wr_bank_q];
  // Strobe is held off while reset is asserted so the reset cycle writes nothing.
  assign wr_en        = sample_valid & sample_ready & ~reset;

  assign wr_bank   = wr_bank_q;
  assign wr_addr   = wr_addr_q;
  assign bank_full = bank_full_q;
  assign overrun   = overrun_q;

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    wr_bank_d   = wr_bank_q;
    wr_addr_d   = wr_addr_q;
    bank_full_d = bank_full_q;
    overrun_d   = overrun_q;

    // Release and fill always target different banks, so both can apply at once.
    if (release_en) begin
      bank_full_d[release_bank] = 1'b0;
    end

    if (wr_en) begin
      if (wr_addr_q == LAST_ADDR) begin
        wr_addr_d              = '0;
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
      end else begin
        wr_addr_d = wr_addr_q + ADDR_W'(1);
      end
    end

    if (sample_valid & ~sample_ready) begin
      overrun_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_q   <= 1'b0;
      wr_addr_q   <= '0;
      bank_full_q <= 2'b00;
      overrun_q   <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      wr_addr_q   <= wr_addr_d;
      bank_full_q <= bank_full_d;
      overrun_q   <= overrun_d;
    end
  end

endmodule

// File: rtl/lpc_frame_sequencer.sv
// Frame scheduler for the LPC analysis path: ping-pong capture plus the compute
// FSM that sequences autocorrelation, Levinson-Durbin and coefficient hand-off.
module lpc_frame_sequencer
  import lpc_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEFAULT,
  parameter int ADDR_W    = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              ac_start,
  output logic              ac_bank,
  input  logic              ac_done,
  output logic              ld_start,
  input  logic              ld_done,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic              overrun,
  output logic              busy
);

  seq_state_e state_q;
  logic       rd_bank_q;
  logic       ac_start_q;
  logic       ac_bank_q;
  logic       ld_start_q;
  logic       coef_valid_q;
  logic       busy_q;
  logic [1:0] bank_full;
  logic       release_en;

  // The bank is handed back to capture in the same cycle the FSM leaves AC_RUN.
  assign release_en = (state_q == AC_RUN) & ac_done;

  lpc_pingpong_capture #(
    .FRAME_LEN (FRAME_LEN),
    .ADDR_W    (ADDR_W)
  ) u_capture (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .release_en   (release_en),
    .release_bank (rd_bank_q),
    .sample_ready (sample_ready),
    .wr_en        (wr_en),
    .wr_bank      (wr_bank),
    .wr_addr      (wr_addr),
    .bank_full    (bank_full),
    .overrun      (overrun)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rd_bank_q    <= 1'b0;
      ac_start_q   <= 1'b0;
      ac_bank_q    <= 1'b0;
      ld_start_q   <= 1'b0;
      coef_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      ac_start_q <= 1'b0;
      ld_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bank_full[rd_bank_q]) begin
            state_q    <= AC_KICK;
            ac_start_q <= 1'b1;
            ac_bank_q  <= rd_bank_q;
            busy_q     <= 1'b1;
          end
        end
        AC_KICK:  state_q <= AC_GUARD;
        // The engine's done flag is stale for one cycle after a restart.
        AC_GUARD: state_q <= AC_RUN;
        AC_RUN: begin
          if (ac_done) begin
            state_q    <= LD_KICK;
            ld_start_q <= 1'b1;
            rd_bank_q  <= ~rd_bank_q;
          end
        end
        LD_KICK:  state_q <= LD_RUN;
        LD_RUN: begin
          if (ld_done) begin
            state_q      <= OUT;
            coef_valid_q <= 1'b1;
          end
        end
        OUT: begin
          if (coef_ready) begin
            state_q      <= IDLE;
            coef_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ac_start   = ac_start_q;
  assign ac_bank    = ac_bank_q;
  assign ld_start   = ld_start_q;
  assign coef_valid = coef_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_lpc_frame_sequencer.sv
// Scoreboard bench for lpc_frame_sequencer: a frame-count reference model
// predicts writes and compute handshakes, a monitor compares DUT outputs.
module tb_lpc_frame_sequencer;

  localparam int FL = 160;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_valid = 1'b0;
  logic          ac_done = 1'b0;
  logic          ld_done = 1'b0;
  logic          coef_ready = 1'b0;
  logic          sample_ready, wr_en, wr_bank;
  logic [AW-1:0] wr_addr;
  logic          ac_start, ac_bank, ld_start, coef_valid, overrun, busy;

  lpc_frame_sequencer #(.FRAME_LEN(FL), .ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .wr_en        (wr_en),
    .wr_bank      (wr_bank),
    .wr_addr      (wr_addr),
    .ac_start     (ac_start),
    .ac_bank      (ac_bank),
    .ac_done      (ac_done),
    .ld_start     (ld_start),
    .ld_done      (ld_done),
    .coef_valid   (coef_valid),
    .coef_ready   (coef_ready),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard queues, each entry tagged with the cycle it is due.
  typedef struct { int cyc; int bank; int addr; } wr_exp_t;
  typedef struct { int cyc; int bank; } ac_exp_t;
  wr_exp_t wr_q[$];
  ac_exp_t ac_q[$];
  int      ld_q[$];
  int      hs_q[$];

  // Reference model: frames accepted vs frames released, plus the timeline of
  // the frame currently being processed (kick, release, Levinson done).
  int  n_acc, rel, full_frames, k_at, r_at, d_at;
  bit  active, ovr;
  bit  exp_ready, exp_overrun, exp_busy, exp_cv, chk_en;
  wr_exp_t wtmp;
  ac_exp_t atmp;

  initial begin
    chk_en = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        n_acc = 0; rel = 0; active = 0; ovr = 0;
        k_at = -1; r_at = -1; d_at = -1;
        wr_q.delete(); ac_q.delete(); ld_q.delete(); hs_q.delete();
        chk_en = 0;
      end else begin
        full_frames = n_acc / FL;
        exp_ready   = (full_frames - rel) < 2;
        exp_overrun = ovr;
        exp_busy    = active && (cyc >= k_at);
        exp_cv      = (d_at >= 0) && (cyc > d_at);
        chk_en      = 1;
        if (sample_valid) begin
          if (exp_ready) begin
            wtmp.cyc = cyc; wtmp.bank = (n_acc / FL) % 2; wtmp.addr = n_acc % FL;
            wr_q.push_back(wtmp);
            n_acc++;
          end else begin
            ovr = 1;
          end
        end
        if (!active) begin
          if (full_frames > rel) begin
            active = 1; k_at = cyc + 1;
            atmp.cyc = k_at; atmp.bank = rel % 2;
            ac_q.push_back(atmp);
          end
        end else if (r_at < 0) begin
          if (cyc >= k_at + 2 && ac_done) begin
            r_at = cyc; rel++;
            ld_q.push_back(cyc + 1);
          end
        end else if (d_at < 0) begin
          if (cyc >= r_at + 2 && ld_done) d_at = cyc;
        end else if (cyc > d_at && coef_ready) begin
          hs_q.push_back(cyc);
          active = 0; k_at = -1; r_at = -1; d_at = -1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  wr_exp_t we;
  ac_exp_t ae;
  int      ltmp;

  initial forever begin
    @(negedge clk); #1;
    if (!reset && chk_en) begin
      check("sample_ready", sample_ready, exp_ready);
      check("overrun", overrun, exp_overrun);
      check("busy", busy, exp_busy);
      check("coef_valid", coef_valid, exp_cv);

      if (wr_en) begin
        if (wr_q.size() == 0) check("wr_en unexpected", wr_en, 0);
        else begin
          we = wr_q.pop_front();
          check("wr cycle", cyc, we.cyc);
          check("wr_bank", wr_bank, we.bank);
          check("wr_addr", wr_addr, we.addr);
        end
      end else if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
        check("wr_en missing", wr_en, 1);
        wr_q.delete(0);
      end

      if (ac_start) begin
        if (ac_q.size() == 0) check("ac_start unexpected", ac_start, 0);
        else begin
          ae = ac_q.pop_front();
          check("ac_start cycle", cyc, ae.cyc);
          check("ac_bank", ac_bank, ae.bank);
        end
      end else if (ac_q.size() > 0 && ac_q[0].cyc <= cyc) begin
        check("ac_start missing", ac_start, 1);
        ac_q.delete(0);
      end

      if (ld_start) begin
        if (ld_q.size() == 0) check("ld_start unexpected", ld_start, 0);
        else begin
          ltmp = ld_q.pop_front();
          check("ld_start cycle", cyc, ltmp);
        end
      end else if (ld_q.size() > 0 && ld_q[0] <= cyc) begin
        check("ld_start missing", ld_start, 1);
        ld_q.delete(0);
      end

      if (coef_valid && coef_ready) begin
        if (hs_q.size() == 0) check("coef handshake unexpected", coef_valid, 0);
        else begin
          ltmp = hs_q.pop_front();
          check("coef handshake cycle", cyc, ltmp);
        end
      end else if (hs_q.size() > 0 && hs_q[0] <= cyc) begin
        check("coef handshake missing", coef_valid, 1);
        hs_q.delete(0);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic stream(input int n);
    sample_valid = 1'b1;
    repeat (n) tick();
    sample_valid = 1'b0;
  endtask

  // Bounded wait (at negedges) for ac_start (sel 0) or ld_start (sel 1).
  task automatic wait_pulse(input int sel, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((sel == 0 && ac_start) || (sel == 1 && ld_start)) begin
        at = cyc;
        break;
      end
    end
  endtask

  int t0, t1;

  initial begin
    repeat (3) tick();
    reset = 1'b0;

    // Frame into bank 0; kick two cycles after the last write.
    stream(FL);
    repeat (3) tick();
    @(negedge clk);
    check("wr_bank after frame 0", wr_bank, 1);
    check("ac_bank frame 0", ac_bank, 0);
    check("busy during frame 0", busy, 1);

    // Fill bank 1 with engines stalled, then one sample too many.
    tick();
    stream(FL);
    stream(1);
    @(negedge clk);
    check("ready low with both full", sample_ready, 0);
    check("overrun set", overrun, 1);
    check("dropped sample wr_addr", wr_addr, 0);

    // Long AC stall, then release of bank 0.
    repeat (1760) tick();
    ac_done = 1'b1;
    tick();
    ac_done = 1'b0;
    @(negedge clk);
    check("ready after release", sample_ready, 1);
    check("ld_start after release", ld_start, 1);

    // Levinson done, coefficients held under back-pressure.
    tick();
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("coef_valid held", coef_valid, 1);
      tick();
    end
    coef_ready = 1'b1;
    tick();
    coef_ready = 1'b0;
    ac_done = 1'b1;
    @(negedge clk);
    check("coef_valid dropped", coef_valid, 0);

    // ac_done already high through the kick: guard cycle still spent.
    wait_pulse(0, 10, t0);
    wait_pulse(1, 10, t1);
    check("ac_start seen for bank 1", (t0 >= 0), 1);
    check("kick to ld_start cycles", t1 - t0, 3);
    tick();
    ac_done = 1'b0;
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    coef_ready = 1'b1;
    tick();
    coef_ready = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      sample_valid = ($urandom_range(0, 9) < 7);
      ac_done      = ($urandom_range(0, 9) < 2);
      ld_done      = ($urandom_range(0, 9) < 2);
      coef_ready   = ($urandom_range(0, 9) < 5);
      tick();
    end
    sample_valid = 1'b0; ac_done = 1'b0; ld_done = 1'b0; coef_ready = 1'b0;

    // Reset mid-frame of bank 1 while Levinson is running.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    stream(FL);
    repeat (3) tick();
    ac_done = 1'b1;
    tick();
    ac_done = 1'b0;
    stream(80);
    @(negedge clk);
    check("busy in LD_RUN", busy, 1);
    check("wr_addr at sample 80", wr_addr, 80);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst sample_ready", sample_ready, 1);
    check("rst wr_en", wr_en, 0);
    check("rst wr_bank", wr_bank, 0);
    check("rst wr_addr", wr_addr, 0);
    check("rst ac_start", ac_start, 0);
    check("rst ac_bank", ac_bank, 0);
    check("rst ld_start", ld_start, 0);
    check("rst coef_valid", coef_valid, 0);
    check("rst overrun", overrun, 0);
    check("rst busy", busy, 0);

    // Fresh frame after reset lands at bank 0, addr 0; then drain.
    tick();
    stream(FL);
    ac_done = 1'b1; ld_done = 1'b1; coef_ready = 1'b1;
    repeat (20) tick();
    ac_done = 1'b0; ld_done = 1'b0; coef_ready = 1'b0;
    repeat (5) tick();
    @(negedge clk); #2;
    check("pending writes", wr_q.size(), 0);
    check("pending ac_start", ac_q.size(), 0);
    check("pending ld_start", ld_q.size(), 0);
    check("pending handshakes", hs_q.size(), 0);
    check("idle at end", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
